writeback_stage: RTL and testbench

Final (WB) pipeline stage of the MIPS core and the single writer of the register file's write port. It captures the MEM-stage result in a MEM/WB pipeline register and selects ALU result or load data. For `lb` it extracts the addressed byte. It drives `RegWr_ID`, `Write_data`, `RegWrite` and `Load_Byte_control` into `registerFile`. It also suppresses writes to `$zero`, honours stall/flush from the hazard unit, and counts retired instructions.

---
 rtl/writeback_stage.sv | 117 +++++++++++
 tb/tb_writeback_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and the register-file write port.
// Selects the ALU result or the load data, extracts the addressed byte for lb,
// blocks writes to $zero, and counts the instructions that leave WB.
module writeback_stage #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Stall_WB,
    input  logic                Flush_WB,
    input  logic                Valid_MEM,
    input  logic                RegWrite_MEM,
    input  logic                MemToReg_MEM,
    input  logic                Load_Byte_MEM,
    input  logic [4:0]          RegWr_MEM,
    input  logic [31:0]         ALU_result_MEM,
    input  logic [31:0]         Mem_data_MEM,
    input  logic [1:0]          Addr_low_MEM,
    output logic [4:0]          RegWr_ID,
    output logic [31:0]         Write_data,
    output logic                RegWrite,
    output logic                Load_Byte_control,
    output logic [RETIRE_W-1:0] Retired_count,
    output logic                Err_zero_write
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    logic              wb_v;
    logic              wb_rw;
    logic              wb_m2r;
    logic              wb_lb;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_mem;
    logic [1:0]        wb_off;

    logic              act;
    logic              zero_hit;
    logic              retire;
    logic [BYTE_W-1:0] sel_byte;

    // MEM/WB register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || Flush_WB) begin
            wb_v   <= 1'b0;
            wb_rw  <= 1'b0;
            wb_m2r <= 1'b0;
            wb_lb  <= 1'b0;
            wb_rd  <= '0;
            wb_alu <= '0;
            wb_mem <= '0;
            wb_off <= '0;
        end else if (!Stall_WB) begin
            wb_v   <= Valid_MEM;
            wb_rw  <= RegWrite_MEM;
            wb_m2r <= MemToReg_MEM;
            wb_lb  <= Load_Byte_MEM;
            wb_rd  <= RegWr_MEM;
            wb_alu <= ALU_result_MEM;
            wb_mem <= Mem_data_MEM;
            wb_off <= Addr_low_MEM;
        end
    end

    // Little-endian byte select for lb
    always_comb begin
        sel_byte = wb_mem[7:0];
        case (wb_off)
            2'd0:    sel_byte = wb_mem[7:0];
            2'd1:    sel_byte = wb_mem[15:8];
            2'd2:    sel_byte = wb_mem[23:16];
            default: sel_byte = wb_mem[31:24];
        endcase
    end

    // Write-port decode, driven only from WB register state
    always_comb begin
        zero_hit          = wb_v & wb_rw & (wb_rd == '0);
        act               = wb_v & wb_rw & (wb_rd != '0);
        retire            = wb_v & (~Stall_WB | Flush_WB);
        RegWrite          = act;
        RegWr_ID          = act ? wb_rd : '0;
        Load_Byte_control = act & wb_m2r & wb_lb;
        Write_data        = '0;
        if (act) begin
            if (!wb_m2r) begin
                Write_data = wb_alu;
            end else if (!wb_lb) begin
                Write_data = wb_mem;
            end else begin
                Write_data = {(DATA_W - BYTE_W)'(0), sel_byte};
            end
        end
    end

    // Sticky $zero-write error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            Err_zero_write <= 1'b0;
        end else if (zero_hit) begin
            Err_zero_write <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            Retired_count <= '0;
        end else if (retire) begin
            Retired_count <= Retired_count + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed and random stimulus against a behavioural model
// of the WB stage, compared on every negative clock edge after reset.
module tb_writeback_stage;

    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Stall_WB = 1'b0;
    logic          Flush_WB = 1'b0;
    logic          Valid_MEM = 1'b0;
    logic          RegWrite_MEM = 1'b0;
    logic          MemToReg_MEM = 1'b0;
    logic          Load_Byte_MEM = 1'b0;
    logic [4:0]    RegWr_MEM = '0;
    logic [31:0]   ALU_result_MEM = '0;
    logic [31:0]   Mem_data_MEM = '0;
    logic [1:0]    Addr_low_MEM = '0;
    logic [4:0]    RegWr_ID;
    logic [31:0]   Write_data;
    logic          RegWrite;
    logic          Load_Byte_control;
    logic [RW-1:0] Retired_count;
    logic          Err_zero_write;

    int passed = 0;
    int total  = 0;
    bit model_on = 1'b0;

    writeback_stage #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .Stall_WB(Stall_WB), .Flush_WB(Flush_WB),
        .Valid_MEM(Valid_MEM), .RegWrite_MEM(RegWrite_MEM),
        .MemToReg_MEM(MemToReg_MEM), .Load_Byte_MEM(Load_Byte_MEM),
        .RegWr_MEM(RegWr_MEM), .ALU_result_MEM(ALU_result_MEM),
        .Mem_data_MEM(Mem_data_MEM), .Addr_low_MEM(Addr_low_MEM),
        .RegWr_ID(RegWr_ID), .Write_data(Write_data), .RegWrite(RegWrite),
        .Load_Byte_control(Load_Byte_control), .Retired_count(Retired_count),
        .Err_zero_write(Err_zero_write)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently in WB, the error flag, the retire total
    bit          m_v = 0, m_rw = 0, m_m2r = 0, m_lb = 0;
    int unsigned m_rd = 0, m_off = 0;
    logic [31:0] m_alu = 0, m_mem = 0;
    bit          m_err = 0;
    int unsigned m_retired = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_retired <= 0;
            m_err     <= 0;
        end else begin
            if (m_v && (!Stall_WB || Flush_WB)) m_retired <= m_retired + 1;
            if (m_v && m_rw && m_rd == 0) m_err <= 1;
        end
        if (rst || Flush_WB) begin
            {m_v, m_rw, m_m2r, m_lb} <= 4'b0;
            m_rd <= 0; m_off <= 0; m_alu <= 0; m_mem <= 0;
        end else if (!Stall_WB) begin
            m_v <= Valid_MEM; m_rw <= RegWrite_MEM; m_m2r <= MemToReg_MEM;
            m_lb <= Load_Byte_MEM; m_rd <= RegWr_MEM; m_off <= Addr_low_MEM;
            m_alu <= ALU_result_MEM; m_mem <= Mem_data_MEM;
        end
    end

    function automatic bit exp_we();
        return m_v && m_rw && (m_rd != 0);
    endfunction

    function automatic logic [31:0] exp_data();
        if (!exp_we()) return 32'h0;
        if (!m_m2r) return m_alu;
        if (!m_lb) return m_mem;
        return (m_mem >> (8 * m_off)) & 32'hFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_on) begin
            check("RegWrite", 32'(RegWrite), 32'(exp_we()));
            check("RegWr_ID", 32'(RegWr_ID), exp_we() ? m_rd : 0);
            check("Write_data", Write_data, exp_data());
            check("Load_Byte_control", 32'(Load_Byte_control), 32'(exp_we() && m_m2r && m_lb));
            check("Retired_count", 32'(Retired_count), m_retired % (1 << RW));
            check("Err_zero_write", 32'(Err_zero_write), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r, input bit lb,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [1:0] off);
        Valid_MEM = v; RegWrite_MEM = rw; MemToReg_MEM = m2r; Load_Byte_MEM = lb;
        RegWr_MEM = rd; ALU_result_MEM = alu; Mem_data_MEM = mem; Addr_low_MEM = off;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    logic [31:0] lb_exp [4];
    logic [RW-1:0] c0;

    initial begin
        lb_exp[0] = 32'hEF; lb_exp[1] = 32'hBE; lb_exp[2] = 32'hAD; lb_exp[3] = 32'hDE;

        bubble();
        do_reset();
        model_on = 1;
        check("rst RegWrite", 32'(RegWrite), 32'h0);
        check("rst Write_data", Write_data, 32'h0);
        check("rst Retired_count", 32'(Retired_count), 32'h0);
        check("rst Err_zero_write", 32'(Err_zero_write), 32'h0);

        // ALU write
        drive(1, 1, 0, 0, 5'd8, 32'h0A12, 32'hFFFF_FFFF, 2'd3);
        tick();
        check("alu RegWrite", 32'(RegWrite), 32'h1);
        check("alu RegWr_ID", 32'(RegWr_ID), 32'd8);
        check("alu Write_data", Write_data, 32'h0A12);
        check("alu Load_Byte_control", 32'(Load_Byte_control), 32'h0);
        bubble(); tick();
        check("alu Retired_count", 32'(Retired_count), 32'd1);

        // Load byte sweep
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1, 5'd3, 32'h1111_1111, 32'hDEADBEEF, 2'(i));
            tick();
            check($sformatf("lb off%0d Write_data", i), Write_data, lb_exp[i]);
            check($sformatf("lb off%0d Load_Byte_control", i), 32'(Load_Byte_control), 32'h1);
        end

        // $zero target
        drive(1, 1, 0, 0, 5'd0, 32'h1234, 32'h0, 2'd0);
        tick();
        check("zero RegWrite", 32'(RegWrite), 32'h0);
        check("zero Write_data", Write_data, 32'h0);
        bubble(); tick();
        check("zero Err set", 32'(Err_zero_write), 32'h1);
        tick(); tick();
        check("zero Err sticky", 32'(Err_zero_write), 32'h1);

        // Stall then stall+flush
        drive(1, 1, 0, 0, 5'd9, 32'h55, 32'h0, 2'd0);
        tick();
        c0 = Retired_count;
        Stall_WB = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 5'(i + 20), $urandom, $urandom, 2'(i));
            tick();
            check("stall RegWr_ID", 32'(RegWr_ID), 32'd9);
            check("stall Write_data", Write_data, 32'h55);
            check("stall Retired_count", 32'(Retired_count), 32'(c0));
        end
        Flush_WB = 1;
        tick();
        Stall_WB = 0; Flush_WB = 0;
        check("flush RegWrite", 32'(RegWrite), 32'h0);
        check("flush Retired_count", 32'(Retired_count), 32'(RW'(c0 + 1)));

        // Counter wrap: 17 back-to-back then a bubble
        do_reset();
        check("rst clears Err", 32'(Err_zero_write), 32'h0);
        for (int i = 0; i < 17; i++) begin
            drive(1, ($urandom & 1) == 1, 0, 0, 5'($urandom), $urandom, $urandom, 2'd0);
            tick();
        end
        bubble(); tick();
        check("wrap Retired_count", 32'(Retired_count), 32'd1);

        // Reset while stalled on a valid write
        drive(1, 1, 0, 0, 5'd7, 32'hCAFE, 32'h0, 2'd0);
        tick();
        Stall_WB = 1; tick();
        rst = 1; tick();
        check("rst-stall RegWrite", 32'(RegWrite), 32'h0);
        check("rst-stall Write_data", Write_data, 32'h0);
        check("rst-stall Retired_count", 32'(Retired_count), 32'h0);
        rst = 0; Stall_WB = 0; bubble(); tick();
        check("rst-stall no reissue", 32'(RegWrite), 32'h0);
        check("rst-stall count held", 32'(Retired_count), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom & 1) == 1,
                  ($urandom & 1) == 1, (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom, 2'($urandom));
            Stall_WB = ($urandom % 5) == 0;
            Flush_WB = ($urandom % 9) == 0;
            rst      = ($urandom % 200) == 0;
            tick();
        end
        rst = 0; Stall_WB = 0; Flush_WB = 0; bubble();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
